// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stall, branch flush, data-memory wait freeze,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int TMO_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_branch_i,
  input  logic             id_eq_i,
  input  logic             id_jump_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [7:0] TMO_LIM = 8'(TMO_CYCLES);

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, br, mw;
  logic pc_write_c, ifid_stall_c, ifid_flush_c, idex_bubble_c, freeze_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}})) r = v + CNT_W'(1);
    return r;
  endfunction

  always_comb begin
    lu = ex_memread_i && (ex_rt_i != 5'd0) &&
         ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    br = (id_branch_i && id_eq_i) || id_jump_i;
    mw = mem_req_i && !mem_ack_i;
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    timeout_d     = timeout_q;
    pc_write_c    = 1'b1;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    freeze_c      = 1'b0;
    case (state_q)
      RUN: begin
        if (mw) begin
          freeze_c     = 1'b1;
          pc_write_c   = 1'b0;
          ifid_stall_c = 1'b1;
          state_d      = MEM_WAIT;
          wcnt_d       = 8'd1;
        end else if (lu) begin
          // A pending branch waits here; it resolves once the bubble has gone down.
          pc_write_c    = 1'b0;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (br) begin
          ifid_flush_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        freeze_c     = !mem_ack_i;
        ifid_stall_c = !mem_ack_i;
        pc_write_c   = mem_ack_i;
        if (mem_ack_i) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == TMO_LIM) begin
          // Forced release: the MEM stage is expected to reissue the access.
          timeout_d = 1'b1;
          state_d   = RUN;
          wcnt_d    = 8'd0;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Gating with the reset level keeps outputs quiet the instant reset asserts.
  always_comb begin
    pc_write_o    = rst_i & pc_write_c;
    ifid_stall_o  = rst_i & ifid_stall_c;
    ifid_flush_o  = rst_i & ifid_flush_c;
    idex_bubble_o = rst_i & idex_bubble_c;
    freeze_o      = rst_i & freeze_c;
  end

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, !pc_write_c);
    flush_cnt_d = sat_inc(flush_cnt_q, ifid_flush_c);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      wcnt_q      <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a rule-level model of the sequencer.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int TMO   = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [4:0]       id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
  logic             id_uses_rt_i = 0, id_branch_i = 0, id_eq_i = 0, id_jump_i = 0;
  logic             ex_memread_i = 0, mem_req_i = 0, mem_ack_i = 0;
  logic             pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, freeze_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .TMO_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .id_branch_i(id_branch_i), .id_eq_i(id_eq_i), .id_jump_i(id_jump_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o), .timeout_o(timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model state: are we waiting on memory, how many unacknowledged wait cycles have passed,
  // the sticky timeout, and the two event tallies.
  logic m_waiting;
  int   m_waits;
  logic m_tmo;
  int   m_stalls, m_flushes;

  typedef struct packed {
    logic pc, st, fl, bu, fr;
  } ctl_t;

  function automatic ctl_t expect_ctl();
    ctl_t c;
    logic hazard, taken, busy;
    c = '0;
    if (!rst_i) return c;
    hazard = ex_memread_i && ex_rt_i != 0 &&
             (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
    taken  = (id_branch_i && id_eq_i) || id_jump_i;
    busy   = mem_req_i && !mem_ack_i;
    if (m_waiting) begin
      c.fr = !mem_ack_i; c.st = !mem_ack_i; c.pc = mem_ack_i;
    end else if (busy) begin
      c.fr = 1; c.st = 1;
    end else if (hazard) begin
      c.st = 1; c.bu = 1;
    end else begin
      c.pc = 1; c.fl = taken;
    end
    return c;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    ctl_t c;
    if (!rst_i) begin
      m_waiting <= 0; m_waits <= 0; m_tmo <= 0; m_stalls <= 0; m_flushes <= 0;
    end else begin
      c = expect_ctl();
      if (!c.pc && m_stalls < MAXC) m_stalls <= m_stalls + 1;
      if (c.fl && m_flushes < MAXC) m_flushes <= m_flushes + 1;
      if (m_waiting) begin
        if (mem_ack_i) begin
          m_waiting <= 0; m_waits <= 0;
        end else if (m_waits + 1 == TMO) begin
          m_tmo <= 1; m_waiting <= 0; m_waits <= 0;
        end else begin
          m_waits <= m_waits + 1;
        end
      end else if (mem_req_i && !mem_ack_i) begin
        m_waiting <= 1; m_waits <= 0;
      end
    end
  end

  always begin
    ctl_t c;
    @(negedge clk_i);
    #2;
    c = expect_ctl();
    chk("pc_write",    int'(pc_write_o),    int'(c.pc));
    chk("ifid_stall",  int'(ifid_stall_o),  int'(c.st));
    chk("ifid_flush",  int'(ifid_flush_o),  int'(c.fl));
    chk("idex_bubble", int'(idex_bubble_o), int'(c.bu));
    chk("freeze",      int'(freeze_o),      int'(c.fr));
    chk("timeout",     int'(timeout_o),     int'(m_tmo));
    chk("stall_cnt",   int'(stall_cnt_o),   m_stalls);
    chk("flush_cnt",   int'(flush_cnt_o),   m_flushes);
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    id_rs_i = 0; id_rt_i = 0; ex_rt_i = 0; id_uses_rt_i = 0; id_branch_i = 0;
    id_eq_i = 0; id_jump_i = 0; ex_memread_i = 0; mem_req_i = 0; mem_ack_i = 0;
  endtask

  initial begin
    // Reset state
    tick(); #1;
    chk("rst_pc", int'(pc_write_o), 0);
    chk("rst_freeze", int'(freeze_o), 0);
    chk("rst_cnt", int'(stall_cnt_o), 0);
    tick(); rst_i = 1; #1;
    chk("idle_pc", int'(pc_write_o), 1);

    // Load-use on rs
    tick(); ex_memread_i = 1; ex_rt_i = 2; id_rs_i = 2; #1;
    chk("lu_pc", int'(pc_write_o), 0);
    chk("lu_stall", int'(ifid_stall_o), 1);
    chk("lu_bubble", int'(idex_bubble_o), 1);
    tick(); ex_memread_i = 0; #1;
    chk("lu_release_pc", int'(pc_write_o), 1);
    chk("lu_stall_cnt", int'(stall_cnt_o), 1);

    // r0 is never a hazard
    tick(); idle_inputs(); ex_memread_i = 1; #1;
    chk("r0_pc", int'(pc_write_o), 1);
    chk("r0_stall", int'(ifid_stall_o), 0);

    // Load-use through rt
    tick(); ex_rt_i = 5; id_rs_i = 1; id_rt_i = 5; id_uses_rt_i = 1; #1;
    chk("lu_rt_stall", int'(ifid_stall_o), 1);

    // Taken branch alone
    tick(); idle_inputs(); id_branch_i = 1; id_eq_i = 1; #1;
    chk("br_flush", int'(ifid_flush_o), 1);
    chk("br_pc", int'(pc_write_o), 1);
    chk("br_fcnt0", int'(flush_cnt_o), 0);
    chk("br_scnt", int'(stall_cnt_o), 2);
    tick(); id_branch_i = 0; id_eq_i = 0; #1;
    chk("br_fcnt1", int'(flush_cnt_o), 1);

    // Branch together with load-use: flush deferred a cycle
    tick(); id_branch_i = 1; id_eq_i = 1; ex_memread_i = 1; ex_rt_i = 3; id_rs_i = 3; #1;
    chk("lubr_flush", int'(ifid_flush_o), 0);
    chk("lubr_stall", int'(ifid_stall_o), 1);
    tick(); ex_memread_i = 0; #1;
    chk("lubr_flush_next", int'(ifid_flush_o), 1);

    // Memory wait acknowledged after three frozen cycles
    tick(); idle_inputs(); mem_req_i = 1; #1;
    chk("mw_fcnt", int'(flush_cnt_o), 2);
    chk("mw_freeze1", int'(freeze_o), 1);
    tick(); #1; chk("mw_freeze2", int'(freeze_o), 1);
    tick(); #1; chk("mw_freeze3", int'(freeze_o), 1);
    tick(); mem_ack_i = 1; #1;
    chk("mw_ack_freeze", int'(freeze_o), 0);
    chk("mw_ack_pc", int'(pc_write_o), 1);
    tick(); idle_inputs(); #1;
    chk("mw_scnt", int'(stall_cnt_o), 6);

    // Never-acknowledged access times out after TMO wait cycles
    tick(); mem_req_i = 1; #1;
    chk("tmo_entry_freeze", int'(freeze_o), 1);
    for (int i = 0; i < TMO; i++) begin
      tick(); #1;
      chk("tmo_wait_freeze", int'(freeze_o), 1);
      chk("tmo_not_yet", int'(timeout_o), 0);
    end
    tick(); mem_req_i = 0; #1;
    chk("tmo_set", int'(timeout_o), 1);
    chk("tmo_released", int'(pc_write_o), 1);
    chk("tmo_scnt", int'(stall_cnt_o), 11);
    tick(); #1; chk("tmo_sticky", int'(timeout_o), 1);

    // Reset in the middle of a memory wait
    tick(); mem_req_i = 1;
    tick(); #1; chk("rstmw_freeze", int'(freeze_o), 1);
    #2 rst_i = 0; #1;
    chk("rstmw_freeze0", int'(freeze_o), 0);
    chk("rstmw_stall0", int'(ifid_stall_o), 0);
    chk("rstmw_pc0", int'(pc_write_o), 0);
    chk("rstmw_cnt0", int'(stall_cnt_o), 0);
    chk("rstmw_tmo0", int'(timeout_o), 0);
    tick(); rst_i = 1; mem_req_i = 0; #1;
    chk("rstmw_run", int'(pc_write_o), 1);

    // Stall counter saturation
    tick(); ex_memread_i = 1; ex_rt_i = 7; id_rs_i = 7;
    for (int i = 0; i < 18; i++) tick();
    ex_memread_i = 0; #1;
    chk("sat_full", int'(stall_cnt_o), MAXC);
    tick(); ex_memread_i = 1;
    tick(); ex_memread_i = 0; #1;
    chk("sat_hold", int'(stall_cnt_o), MAXC);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!rst_i) rst_i = 1;
      id_rs_i      = 5'($urandom_range(0, 3));
      id_rt_i      = 5'($urandom_range(0, 3));
      ex_rt_i      = 5'($urandom_range(0, 3));
      id_uses_rt_i = ($urandom_range(0, 1) == 1);
      id_branch_i  = ($urandom_range(0, 3) == 0);
      id_eq_i      = ($urandom_range(0, 1) == 1);
      id_jump_i    = ($urandom_range(0, 9) == 0);
      ex_memread_i = ($urandom_range(0, 2) == 0);
      mem_req_i    = ($urandom_range(0, 4) == 0);
      mem_ack_i    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #3 rst_i = 0;
      end
    end

    tick(); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
